// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters with registered sync,
// visible flag, active-relative coordinates, line/frame strobes and a
// frame counter. Every output is registered from the same next-state
// decode, so all outputs describe one (h,v) pair on any given cycle.
module vga_timing_gen #(
   parameter int unsigned H_SYNC    = 136,
   parameter int unsigned H_BACK    = 200,
   parameter int unsigned H_ACTIVE  = 1280,
   parameter int unsigned H_FRONT   = 64,
   parameter int unsigned V_SYNC    = 6,
   parameter int unsigned V_BACK    = 21,
   parameter int unsigned V_ACTIVE  = 800,
   parameter int unsigned V_FRONT   = 1,
   parameter bit          HSYNC_POL = 1'b0,
   parameter bit          VSYNC_POL = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        pix_ce,
   output logic [10:0] display_pos_x,
   output logic [9:0]  display_pos_y,
   output logic [10:0] active_x,
   output logic [9:0]  active_y,
   output logic        hsync,
   output logic        vsync,
   output logic        visible,
   output logic        line_start,
   output logic        frame_start,
   output logic [7:0]  frame_count
);

   localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_ACTIVE + H_FRONT;
   localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_ACTIVE + V_FRONT;

   // Region boundaries in counter width; all comparisons are unsigned.
   localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
   localparam logic [10:0] H_SYNC_END = 11'(H_SYNC);
   localparam logic [10:0] H_ACT_BEG  = 11'(H_SYNC + H_BACK);
   localparam logic [10:0] H_ACT_END  = 11'(H_SYNC + H_BACK + H_ACTIVE - 1);
   localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
   localparam logic [9:0]  V_SYNC_END = 10'(V_SYNC);
   localparam logic [9:0]  V_ACT_BEG  = 10'(V_SYNC + V_BACK);
   localparam logic [9:0]  V_ACT_END  = 10'(V_SYNC + V_BACK + V_ACTIVE - 1);

   // Counters must fit their output widths; refuse to elaborate otherwise.
   generate
      if (H_TOTAL > 2048) begin : g_h_too_wide
         $error("vga_timing_gen: H_TOTAL does not fit 11 bits");
      end
      if (V_TOTAL > 1024) begin : g_v_too_wide
         $error("vga_timing_gen: V_TOTAL does not fit 10 bits");
      end
      if (H_ACTIVE == 0 || V_ACTIVE == 0) begin : g_no_active
         $error("vga_timing_gen: active region must be non-empty");
      end
   endgenerate

   // Counter state; display_pos_x/y are these registers with no skew.
   logic [10:0] h_cnt;
   logic [9:0]  v_cnt;

   // Next-state decode
   logic        h_wrap;
   logic        v_wrap;
   logic [10:0] h_nxt;
   logic [9:0]  v_nxt;
   logic        h_vis_nxt;
   logic        v_vis_nxt;
   logic        vis_nxt;
   logic        hsync_nxt;
   logic        vsync_nxt;
   logic [10:0] ax_nxt;
   logic [9:0]  ay_nxt;

   // Advance the raster position and decode every region for the next pair.
   always_comb begin
      h_wrap = (h_cnt == H_LAST);
      v_wrap = (v_cnt == V_LAST);

      h_nxt = h_wrap ? 11'd0 : h_cnt + 11'd1;
      if (h_wrap) begin
         v_nxt = v_wrap ? 10'd0 : v_cnt + 10'd1;
      end else begin
         v_nxt = v_cnt;
      end

      h_vis_nxt = (h_nxt >= H_ACT_BEG) && (h_nxt <= H_ACT_END);
      v_vis_nxt = (v_nxt >= V_ACT_BEG) && (v_nxt <= V_ACT_END);
      vis_nxt   = h_vis_nxt && v_vis_nxt;

      // vsync only changes with v, which only changes on the h wrap.
      hsync_nxt = (h_nxt < H_SYNC_END) ? HSYNC_POL : ~HSYNC_POL;
      vsync_nxt = (v_nxt < V_SYNC_END) ? VSYNC_POL : ~VSYNC_POL;

      ax_nxt = vis_nxt ? h_nxt - H_ACT_BEG : 11'd0;
      ay_nxt = vis_nxt ? v_nxt - V_ACT_BEG : 10'd0;
   end

   // Register counters and level outputs together; hold when pix_ce is low.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         h_cnt       <= 11'd0;
         v_cnt       <= 10'd0;
         active_x    <= 11'd0;
         active_y    <= 10'd0;
         hsync       <= HSYNC_POL;
         vsync       <= VSYNC_POL;
         visible     <= 1'b0;
         frame_count <= 8'd0;
      end else if (pix_ce) begin
         h_cnt    <= h_nxt;
         v_cnt    <= v_nxt;
         active_x <= ax_nxt;
         active_y <= ay_nxt;
         hsync    <= hsync_nxt;
         vsync    <= vsync_nxt;
         visible  <= vis_nxt;
         if (h_wrap && v_wrap) begin
            frame_count <= frame_count + 8'd1;
         end
      end
   end

   // Strobes fire for the single cycle in which the counters land on h=0,
   // and are forced low on idle (pix_ce=0) cycles.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         line_start  <= pix_ce && h_wrap;
         frame_start <= pix_ce && h_wrap && v_wrap;
      end
   end

   assign display_pos_x = h_cnt;
   assign display_pos_y = v_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced raster so that full frames and
// the 8-bit frame counter wrap fit in a short run. A reference model pushes
// the expected output set per clock into a scoreboard; a monitor pops and
// compares one cycle after each driven edge.
module tb_vga_timing_gen;

   localparam int HS = 2, HB = 3, HA = 5, HF = 2;
   localparam int VS = 2, VB = 2, VA = 4, VF = 1;
   localparam int HT = HS + HB + HA + HF;
   localparam int VT = VS + VB + VA + VF;
   localparam int FRAME = HT * VT;
   localparam bit HPOL = 1'b0;
   localparam bit VPOL = 1'b1;

   typedef struct packed {
      logic [10:0] x;
      logic [9:0]  y;
      logic [10:0] ax;
      logic [9:0]  ay;
      logic        hs;
      logic        vs;
      logic        vis;
      logic        ls;
      logic        fs;
      logic [7:0]  fc;
   } obs_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        pix_ce = 1'b0;
   logic [10:0] display_pos_x;
   logic [9:0]  display_pos_y;
   logic [10:0] active_x;
   logic [9:0]  active_y;
   logic        hsync, vsync, visible, line_start, frame_start;
   logic [7:0]  frame_count;

   obs_t got;
   obs_t sb_exp;
   obs_t sb[$];
   int   n_total = 0;
   int   n_bad = 0;
   int   m_h, m_v, m_fc;

   vga_timing_gen #(
      .H_SYNC(HS), .H_BACK(HB), .H_ACTIVE(HA), .H_FRONT(HF),
      .V_SYNC(VS), .V_BACK(VB), .V_ACTIVE(VA), .V_FRONT(VF),
      .HSYNC_POL(HPOL), .VSYNC_POL(VPOL)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pix_ce(pix_ce),
      .display_pos_x(display_pos_x), .display_pos_y(display_pos_y),
      .active_x(active_x), .active_y(active_y),
      .hsync(hsync), .vsync(vsync), .visible(visible),
      .line_start(line_start), .frame_start(frame_start),
      .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   assign got = {display_pos_x, display_pos_y, active_x, active_y,
                 hsync, vsync, visible, line_start, frame_start, frame_count};

   // Expected outputs for raster position (h,v), straight from the region definitions.
   function automatic obs_t model_out(input int h, input int v, input int fc,
                                      input bit ls, input bit fs);
      obs_t o;
      bit   vis;
      vis   = (h >= HS + HB) && (h < HS + HB + HA) &&
              (v >= VS + VB) && (v < VS + VB + VA);
      o.x   = 11'(h);
      o.y   = 10'(v);
      o.ax  = vis ? 11'(h - (HS + HB)) : 11'd0;
      o.ay  = vis ? 10'(v - (VS + VB)) : 10'd0;
      o.hs  = (h < HS) ? HPOL : !HPOL;
      o.vs  = (v < VS) ? VPOL : !VPOL;
      o.vis = vis;
      o.ls  = ls;
      o.fs  = fs;
      o.fc  = 8'(fc);
      return o;
   endfunction

   // Drive one clock of pix_ce, advance the model and queue the expectation.
   task automatic step(input bit ce);
      bit ls, fs;
      ls = 1'b0;
      fs = 1'b0;
      pix_ce = ce;
      if (ce) begin
         if (m_h == HT - 1) begin
            m_h = 0;
            ls  = 1'b1;
            if (m_v == VT - 1) begin
               m_v  = 0;
               fs   = 1'b1;
               m_fc = (m_fc + 1) % 256;
            end else begin
               m_v = m_v + 1;
            end
         end else begin
            m_h = m_h + 1;
         end
      end
      sb.push_back(model_out(m_h, m_v, m_fc, ls, fs));
      @(posedge clk);
      #2;
   endtask

   // Scoreboard monitor: compare every queued expectation one tick after the edge.
   always @(posedge clk) begin
      #1;
      if (sb.size() > 0) begin
         sb_exp = sb.pop_front();
         n_total++;
         if (got !== sb_exp) begin
            n_bad++;
            $display("FAIL scoreboard t=%0t got=%h (x=%0d y=%0d) expected=%h (x=%0d y=%0d)",
                     $time, got, got.x, got.y, sb_exp, sb_exp.x, sb_exp.y);
         end
      end
   end

   task automatic test_reset();
      rst_n = 1'b0;
      pix_ce = 1'b0;
      m_h = 0; m_v = 0; m_fc = 0;
      sb.delete();
      repeat (3) @(posedge clk);
      #2;
      n_total++;
      if (got !== model_out(0, 0, 0, 0, 0)) begin
         n_bad++;
         $display("FAIL reset_values got=%h expected=%h", got, model_out(0, 0, 0, 0, 0));
      end
      n_total++;
      if ({hsync, vsync} !== 2'b01) begin
         n_bad++;
         $display("FAIL reset_sync got=%b%b expected=01", hsync, vsync);
      end
      rst_n = 1'b1;
      repeat (20) step(1'b0);
      n_total++;
      if (got !== model_out(0, 0, 0, 0, 0)) begin
         n_bad++;
         $display("FAIL reset_hold got=%h expected=%h", got, model_out(0, 0, 0, 0, 0));
      end
   endtask

   // First frame: sync edges, line period, and the single frame_start at the wrap.
   task automatic test_sync_frame();
      int prev_ls, fs_cnt;
      prev_ls = -1;
      fs_cnt = 0;
      for (int i = 1; i <= FRAME; i++) begin
         step(1'b1);
         if (display_pos_x == 11'(HS - 1)) begin
            n_total++;
            if (hsync !== HPOL) begin
               n_bad++;
               $display("FAIL hsync_last_sync got=%b expected=%b", hsync, HPOL);
            end
         end
         if (display_pos_x == 11'(HS)) begin
            n_total++;
            if (hsync !== !HPOL) begin
               n_bad++;
               $display("FAIL hsync_deassert got=%b expected=%b", hsync, !HPOL);
            end
         end
         if (display_pos_x == 11'd0 && display_pos_y == 10'(VS)) begin
            n_total++;
            if (vsync !== !VPOL) begin
               n_bad++;
               $display("FAIL vsync_deassert got=%b expected=%b", vsync, !VPOL);
            end
         end
         if (line_start) begin
            if (prev_ls >= 0) begin
               n_total++;
               if (i - prev_ls != HT) begin
                  n_bad++;
                  $display("FAIL line_period got=%0d expected=%0d", i - prev_ls, HT);
               end
            end
            prev_ls = i;
         end
         if (frame_start) fs_cnt++;
      end
      n_total++;
      if (fs_cnt != 1 || !frame_start || display_pos_x !== 11'd0 ||
          display_pos_y !== 10'd0 || frame_count !== 8'd1) begin
         n_bad++;
         $display("FAIL first_frame got fs_cnt=%0d fs=%b x=%0d y=%0d fc=%0d expected 1 1 0 0 1",
                  fs_cnt, frame_start, display_pos_x, display_pos_y, frame_count);
      end
   endtask

   // One frame: visible window edges and area.
   task automatic test_visible();
      int   vis_cnt;
      bit   prev_vis, seen_rise;
      obs_t first_v, last_v;
      vis_cnt = 0;
      prev_vis = 1'b0;
      seen_rise = 1'b0;
      first_v = '0;
      last_v = '0;
      for (int i = 0; i < FRAME; i++) begin
         step(1'b1);
         if (visible) begin
            vis_cnt++;
            if (!prev_vis && !seen_rise) begin
               first_v = got;
               seen_rise = 1'b1;
            end
            last_v = got;
         end
         prev_vis = visible;
      end
      n_total++;
      if (first_v.x !== 11'(HS + HB) || first_v.y !== 10'(VS + VB) ||
          first_v.ax !== 11'd0 || first_v.ay !== 10'd0) begin
         n_bad++;
         $display("FAIL visible_rise got=(%0d,%0d) active=(%0d,%0d) expected=(%0d,%0d) active=(0,0)",
                  first_v.x, first_v.y, first_v.ax, first_v.ay, HS + HB, VS + VB);
      end
      n_total++;
      if (last_v.x !== 11'(HS + HB + HA - 1) || last_v.y !== 10'(VS + VB + VA - 1) ||
          last_v.ax !== 11'(HA - 1) || last_v.ay !== 10'(VA - 1)) begin
         n_bad++;
         $display("FAIL visible_fall got=(%0d,%0d) active=(%0d,%0d) expected=(%0d,%0d) active=(%0d,%0d)",
                  last_v.x, last_v.y, last_v.ax, last_v.ay,
                  HS + HB + HA - 1, VS + VB + VA - 1, HA - 1, VA - 1);
      end
      n_total++;
      if (vis_cnt != HA * VA) begin
         n_bad++;
         $display("FAIL visible_count got=%0d expected=%0d", vis_cnt, HA * VA);
      end
   endtask

   // Run until the 8-bit frame counter wraps back to 0 (frames 3..256).
   task automatic test_frame_wrap();
      int fs_cnt;
      fs_cnt = 0;
      for (int i = 0; i < FRAME * 254; i++) begin
         step(1'b1);
         if (frame_start) fs_cnt++;
      end
      n_total++;
      if (fs_cnt != 254 || frame_count !== 8'd0 || !frame_start) begin
         n_bad++;
         $display("FAIL frame_wrap got fs_cnt=%0d fc=%0d fs=%b expected 254 0 1",
                  fs_cnt, frame_count, frame_start);
      end
   endtask

   // Alternating enable: half rate, one-cycle strobes, doubled line period.
   task automatic test_ce_toggle();
      int clk_i, prev_ls;
      clk_i = 0;
      prev_ls = -1;
      for (int i = 0; i < 4 * HT; i++) begin
         step(1'b1);
         clk_i++;
         if (line_start) begin
            if (prev_ls >= 0) begin
               n_total++;
               if (clk_i - prev_ls != 2 * HT) begin
                  n_bad++;
                  $display("FAIL ce_line_period got=%0d expected=%0d", clk_i - prev_ls, 2 * HT);
               end
            end
            prev_ls = clk_i;
            step(1'b0);
            clk_i++;
            n_total++;
            if (line_start !== 1'b0 || frame_start !== 1'b0) begin
               n_bad++;
               $display("FAIL ce_strobe_width got ls=%b fs=%b expected 0 0", line_start, frame_start);
            end
         end else begin
            step(1'b0);
            clk_i++;
         end
      end
   endtask

   // Asynchronous reset mid-frame, then exactly one full frame to frame_start.
   task automatic test_mid_reset();
      int guard, fs_early;
      guard = 0;
      while (!(m_h == 7 && m_v == 5) && guard < 2 * FRAME) begin
         step(1'b1);
         guard++;
      end
      n_total++;
      if (display_pos_x !== 11'd7 || display_pos_y !== 10'd5) begin
         n_bad++;
         $display("FAIL mid_reset_setup got=(%0d,%0d) expected=(7,5)", display_pos_x, display_pos_y);
      end
      rst_n = 1'b0;
      #1;
      n_total++;
      if (got !== model_out(0, 0, 0, 0, 0)) begin
         n_bad++;
         $display("FAIL async_reset got=%h expected=%h", got, model_out(0, 0, 0, 0, 0));
      end
      repeat (3) @(posedge clk);
      #2;
      n_total++;
      if (got !== model_out(0, 0, 0, 0, 0)) begin
         n_bad++;
         $display("FAIL reset_held got=%h expected=%h", got, model_out(0, 0, 0, 0, 0));
      end
      m_h = 0; m_v = 0; m_fc = 0;
      rst_n = 1'b1;
      step(1'b1);
      n_total++;
      if (display_pos_x !== 11'd1 || display_pos_y !== 10'd0) begin
         n_bad++;
         $display("FAIL post_reset_first got=(%0d,%0d) expected=(1,0)", display_pos_x, display_pos_y);
      end
      fs_early = 0;
      for (int i = 2; i < FRAME; i++) begin
         step(1'b1);
         if (frame_start) fs_early++;
      end
      n_total++;
      if (fs_early != 0) begin
         n_bad++;
         $display("FAIL spurious_frame_start got=%0d expected=0", fs_early);
      end
      step(1'b1);
      n_total++;
      if (!frame_start || frame_count !== 8'd1 || display_pos_x !== 11'd0 || display_pos_y !== 10'd0) begin
         n_bad++;
         $display("FAIL post_reset_frame got fs=%b fc=%0d (%0d,%0d) expected 1 1 (0,0)",
                  frame_start, frame_count, display_pos_x, display_pos_y);
      end
   endtask

   initial begin
      test_reset();
      test_sync_frame();
      test_visible();
      test_frame_wrap();
      test_ce_toggle();
      test_mid_reset();
      @(posedge clk);
      #2;
      n_total++;
      if (sb.size() != 0) begin
         n_bad++;
         $display("FAIL scoreboard_drain got=%0d expected=0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout got=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Free-running raster timing generator for the 1280x800 display path; sits directly upstream of the display-position-to-map-index stage.
Produces raw display counters, which downstream converts to 80x50 matrix indices (16x16 px per cell).
Also produces sync outputs, active-region flags, active-relative coordinates, and line/frame strobes for game logic.
Runs on a single system clock; pix_ce qualifies each pixel.

Parameters:
H_SYNC, 136, hsync pulse width in pixels (h counts 0..135)
H_BACK, 200, horizontal back porch (h 136..335)
H_ACTIVE, 1280, visible pixels (h 336..1615)
H_FRONT, 64, horizontal front porch (h 1616..1679); H_TOTAL = 1680
V_SYNC, 6, vsync width in lines (v 0..5)
V_BACK, 21, vertical back porch (v 6..26)
V_ACTIVE, 800, visible lines (v 27..826)
V_FRONT, 1, vertical front porch (v 827); V_TOTAL = 828
HSYNC_POL, 0, asserted level of hsync (0 = active-low)
VSYNC_POL, 1, asserted level of vsync

Ports:
clk  in  1  system clock
rst_n  in  1  reset, asynchronous, active-low
pix_ce  in  1  pixel clock enable; counters advance only when high
display_pos_x  out  11  raw horizontal counter, 0..H_TOTAL-1
display_pos_y  out  10  raw vertical counter, 0..V_TOTAL-1
active_x  out  11  display_pos_x - (H_SYNC+H_BACK) when visible, else 0
active_y  out  10  display_pos_y - (V_SYNC+V_BACK) when visible, else 0
hsync  out  1  horizontal sync, polarity per HSYNC_POL
vsync  out  1  vertical sync, polarity per VSYNC_POL
visible  out  1  high iff h in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_ACTIVE-1] and v in [V_SYNC+V_BACK, V_SYNC+V_BACK+V_ACTIVE-1]
line_start  out  1  one-clk pulse when h wraps to 0
frame_start  out  1  one-clk pulse when (h,v) wraps to (0,0)
frame_count  out  8  frames completed, wraps 255->0

Behaviour:
- Reset is asynchronous, active-low, on clk.
- Reset values: counters (0,0); display_pos_x=0, display_pos_y=0; active_x=0, active_y=0.
- Reset values, continued: hsync=HSYNC_POL and vsync=VSYNC_POL (count (0,0) lies in both sync regions); visible=0, line_start=0, frame_start=0, frame_count=0.
- All outputs are registered and mutually aligned. On any clk edge, every output describes the same (h,v) pair, and display_pos_x/y equal the internal counters directly (no skew).
- Counter update on clk with pix_ce=1:
  - h = h+1 when h < H_TOTAL-1; otherwise h = 0.
  - On the h wrap, v = v+1 when v < V_TOTAL-1; otherwise v = 0 and frame_count increments.
- pix_ce=0: all counters and level outputs hold their values; line_start and frame_start are driven 0.
- Strobes:
  - line_start is high for exactly one clk cycle, the cycle in which the registered h becomes 0.
  - frame_start is high in the cycle the registered pair becomes (0,0); line_start is also high then.
  - Strobes are not asserted out of reset.
- Sync regions:
  - hsync is asserted iff h < H_SYNC; vsync is asserted iff v < V_SYNC.
  - vsync is line-based: it changes only on the h wrap edge.
- Width rules:
  - H_TOTAL must fit 11 bits and V_TOTAL must fit 10 bits; violation is an elaboration-time error.
  - Comparisons are unsigned.
  - active_x/active_y are computed from the registered counters at the same edge as visible.
- Reset mid-frame: counters return to (0,0) immediately (asynchronous); no frame_start is emitted.
  - After release, the first pix_ce moves the count to (1,0).
  - A full frame later, the wrap emits frame_start and frame_count becomes 1.
- Simultaneous h and v wrap: a single frame_start, a single line_start, and frame_count+1, all in the same cycle.

Test Plan:
- Reset asserted, then released with pix_ce=0 -> outputs (0,0), hsync=0, vsync=1, visible=0, strobes 0, frame_count=0, held indefinitely.
- pix_ce=1 continuous -> hsync low for h 0..135, high at h=136; line_start pulses every 1680 clk; vsync=1 for lines 0..5, 0 from line 6.
- Visible region check:
  - visible first rises at (336,27) with active=(0,0).
  - visible falls after (1615,826), where active=(1279,799).
  - visible count per frame = 1,024,000.
- Run 1680*828 = 1,391,040 enabled cycles -> frame_start pulses exactly once with display_pos=(0,0) and frame_count=1. After 256 frames, frame_count=0.
- pix_ce toggling 1,0,1,0 -> counters advance every other clk; strobes last one clk only; line period = 3360 clk.
- rst_n low at (900,400) for 3 clk -> outputs return to reset values asynchronously; after release, no spurious frame_start before the next full frame.
